// File: rtl/bram_port_arbiter.sv
// Shares one synchronous BRAM port between two req/ack requesters.
// Each access runs IDLE -> ACCESS -> WAIT -> DONE; contention is resolved round-robin.
module bram_port_arbiter #(
    parameter int unsigned P_DATA_WIDTH    = 16,
    parameter int unsigned P_ADDRESS_WIDTH = 10
) (
    input  logic                       I_CLK,
    input  logic                       I_NRESET,
    input  logic [1:0]                 I_REQ,
    input  logic [1:0]                 I_WE,
    input  logic [P_ADDRESS_WIDTH-1:0] I_ADDRESS_0,
    input  logic [P_ADDRESS_WIDTH-1:0] I_ADDRESS_1,
    input  logic [P_DATA_WIDTH-1:0]    I_DATA_0,
    input  logic [P_DATA_WIDTH-1:0]    I_DATA_1,
    output logic [1:0]                 O_ACK,
    output logic [P_DATA_WIDTH-1:0]    O_DATA_0,
    output logic [P_DATA_WIDTH-1:0]    O_DATA_1,
    output logic [P_ADDRESS_WIDTH-1:0] O_BRAM_ADDRESS,
    output logic [P_DATA_WIDTH-1:0]    O_BRAM_DATA,
    output logic                       O_BRAM_WRITE_ENABLE,
    input  logic [P_DATA_WIDTH-1:0]    I_BRAM_DATA
);

    typedef enum logic [1:0] {StIdle, StAccess, StWait, StDone} state_e;

    state_e                     state_q;
    logic                       ptr_q;
    logic                       grant_q;
    logic                       is_write_q;
    logic [1:0]                 ack_q;
    logic [P_DATA_WIDTH-1:0]    data0_q;
    logic [P_DATA_WIDTH-1:0]    data1_q;
    logic [P_ADDRESS_WIDTH-1:0] addr_q;
    logic [P_DATA_WIDTH-1:0]    wdata_q;
    logic                       we_q;
    logic                       grant_d;

    // A lone request wins outright; a tie goes to the priority pointer.
    always_comb begin
        grant_d = I_REQ[1];
        if (I_REQ == 2'b11) begin
            grant_d = ptr_q;
        end
    end

    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            state_q    <= StIdle;
            ptr_q      <= 1'b0;
            grant_q    <= 1'b0;
            is_write_q <= 1'b0;
            ack_q      <= 2'b00;
            data0_q    <= '0;
            data1_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (I_REQ != 2'b00) begin
                        grant_q    <= grant_d;
                        ptr_q      <= ~grant_d;
                        is_write_q <= I_WE[grant_d];
                        we_q       <= I_WE[grant_d];
                        addr_q     <= grant_d ? I_ADDRESS_1 : I_ADDRESS_0;
                        wdata_q    <= grant_d ? I_DATA_1 : I_DATA_0;
                        state_q    <= StAccess;
                    end
                end
                StAccess: begin
                    // Address and data stay put; only the strobe is single-cycle.
                    we_q    <= 1'b0;
                    state_q <= StWait;
                end
                StWait: begin
                    if (!is_write_q) begin
                        if (grant_q) begin
                            data1_q <= I_BRAM_DATA;
                        end else begin
                            data0_q <= I_BRAM_DATA;
                        end
                    end
                    ack_q[grant_q] <= 1'b1;
                    state_q        <= StDone;
                end
                StDone: begin
                    ack_q   <= 2'b00;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign O_ACK               = ack_q;
    assign O_DATA_0            = data0_q;
    assign O_DATA_1            = data1_q;
    assign O_BRAM_ADDRESS      = addr_q;
    assign O_BRAM_DATA         = wdata_q;
    assign O_BRAM_WRITE_ENABLE = we_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Randomized and directed bench for bram_port_arbiter with a transaction-level scoreboard.
module tb_bram_port_arbiter;

    localparam int DW = 16;
    localparam int AW = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wd0, wd1;
    logic [1:0]    ack;
    logic [DW-1:0] rd0, rd1, bdata_o, bram_rdata;
    logic [AW-1:0] baddr;
    logic          bwe;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bram_port_arbiter #(
        .P_DATA_WIDTH   (DW),
        .P_ADDRESS_WIDTH(AW)
    ) dut (
        .I_CLK              (clk),
        .I_NRESET           (rst_n),
        .I_REQ              ({req1, req0}),
        .I_WE               ({we1, we0}),
        .I_ADDRESS_0        (addr0),
        .I_ADDRESS_1        (addr1),
        .I_DATA_0           (wd0),
        .I_DATA_1           (wd1),
        .O_ACK              (ack),
        .O_DATA_0           (rd0),
        .O_DATA_1           (rd1),
        .O_BRAM_ADDRESS     (baddr),
        .O_BRAM_DATA        (bdata_o),
        .O_BRAM_WRITE_ENABLE(bwe),
        .I_BRAM_DATA        (bram_rdata)
    );

    function automatic logic [DW-1:0] init_word(int i);
        if (i == 5) return 16'h1234;
        return DW'((i * 13) ^ 16'h5a5a);
    endfunction

    // Behavioural BRAM: one-cycle read latency.
    logic [DW-1:0] bmem [DEPTH];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) bmem[i] <= init_word(i);
        end else if (bwe) begin
            bmem[baddr] <= bdata_o;
        end
        bram_rdata <= bmem[baddr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: transaction level, one access per 4 edges, round-robin ties.
    typedef struct {
        int            id;
        int            cyc;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
    } exp_t;

    exp_t          q[$];
    logic [DW-1:0] mmem [DEPTH];
    int            busy;
    bit            ptr, exp_we, exp_acc, pend_wr;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wd, md0, md1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mmem[i] = init_word(i);
            busy = 0; ptr = 0; exp_we = 0; exp_acc = 0; pend_wr = 0;
            md0 = '0; md1 = '0;
            q.delete();
        end else begin
            exp_we  = 0;
            exp_acc = 0;
            if (busy == 3 && pend_wr) mmem[exp_addr] = exp_wd;
            if (busy > 0) begin
                busy--;
            end else if (req0 || req1) begin
                int   gid;
                bit   w;
                exp_t e;
                gid      = (req0 && req1) ? int'(ptr) : (req1 ? 1 : 0);
                ptr      = (gid == 0);
                w        = (gid == 1) ? we1 : we0;
                exp_addr = (gid == 1) ? addr1 : addr0;
                exp_wd   = (gid == 1) ? wd1 : wd0;
                exp_acc  = 1;
                exp_we   = w;
                pend_wr  = w;
                busy     = 3;
                if (!w) begin
                    if (gid == 1) md1 = mmem[exp_addr];
                    else md0 = mmem[exp_addr];
                end
                e.id = gid; e.cyc = cyc + 3; e.d0 = md0; e.d1 = md1;
                q.push_back(e);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compares DUT outputs against the model away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            chk("reset_outputs", {3'b0, ack, rd0, rd1, baddr, bdata_o, bwe}, 64'd0);
        end else begin
            chk("bram_we", 64'(bwe), 64'(exp_we));
            if (exp_acc) chk("bram_addr", 64'(baddr), 64'(exp_addr));
            if (exp_we) chk("bram_wdata", 64'(bdata_o), 64'(exp_wd));
            if (ack != 2'b00) begin
                if (q.size() == 0) begin
                    chk("unexpected_ack", 64'(ack), 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("ack_id", 64'(ack), 64'(1) << e.id);
                    chk("ack_cycle", 64'(cyc), 64'(e.cyc));
                    chk("data_0", 64'(rd0), 64'(e.d0));
                    chk("data_1", 64'(rd1), 64'(e.d1));
                end
            end else if (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                chk("missing_ack", 64'(ack), 64'(1) << e.id);
            end
        end
    end

    task automatic op0(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req0 = 1'b1; we0 = w; addr0 = a; wd0 = d;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #2;
            if (ack[0]) break;
        end
        @(posedge clk); #2;
        req0 = 1'b0;
    endtask

    task automatic op1(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req1 = 1'b1; we1 = w; addr1 = a; wd1 = d;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #2;
            if (ack[1]) break;
        end
        @(posedge clk); #2;
        req1 = 1'b0;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return AW'(DEPTH - 1);
        return AW'($urandom_range(0, 7));
    endfunction

    initial begin
        rst_n = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wd0 = '0; wd1 = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;

        op0(1'b0, 10'd5, 16'h0);                  // single read
        op1(1'b1, 10'd1023, 16'h00AA);            // write then read at top address
        op1(1'b0, 10'd1023, 16'h0);

        fork                                      // late arrival during WAIT
            op0(1'b0, 10'd5, 16'h0);
            begin
                repeat (2) begin @(posedge clk); #2; end
                op1(1'b0, 10'd3, 16'h0);
            end
        join
        repeat (3) begin @(posedge clk); #2; end

        fork                                      // withdrawal while requester 1 is in DONE
            op1(1'b0, 10'd9, 16'h0);
            begin
                for (int i = 0; i < 40; i++) begin
                    @(posedge clk); #2;
                    if (ack[1]) break;
                end
                req0 = 1'b1; we0 = 1'b0; addr0 = 10'd4;
                @(posedge clk); #2;
                req0 = 1'b0;
            end
        join
        repeat (8) begin @(posedge clk); #2; end

        // Reset in the middle of a write's ACCESS cycle.
        req1 = 1'b1; we1 = 1'b1; addr1 = 10'd77; wd1 = 16'hBEEF;
        @(posedge clk); #2;
        rst_n = 1'b0; req1 = 1'b0; we1 = 1'b0;
        repeat (2) begin @(posedge clk); #2; end
        rst_n = 1'b1;
        @(posedge clk); #2;
        fork                                      // pointer restarts at requester 0
            op0(1'b0, 10'd0, 16'h0);
            op1(1'b0, 10'd1, 16'h0);
        join

        fork                                      // sustained contention
            repeat (3) op0(1'b0, 10'd0, 16'h0);
            repeat (3) op1(1'b0, 10'd1, 16'h0);
        join

        fork                                      // random mix
            for (int k = 0; k < 30; k++) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #2; end
                op0(1'($urandom_range(0, 1)), rand_addr(), DW'($urandom));
            end
            for (int k = 0; k < 30; k++) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #2; end
                op1(1'($urandom_range(0, 1)), rand_addr(), DW'($urandom));
            end
        join

        repeat (10) @(posedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one synchronous BRAM port (registered address, write enable and write data; one-cycle read latency) between two requesters.
- Typical pairing: CPU data path plus a loader/debug engine.
- Uses a req/ack handshake, a fixed 4-state access sequence and round-robin arbitration between the requesters.
- Sits between the requesters and one port (A or B) of a bram instance.

Parameters:
P_DATA_WIDTH, 16, width of data words.
P_ADDRESS_WIDTH, 10, width of BRAM addresses.

Ports:
I_CLK  input  1  clock; all state changes on posedge.
I_NRESET  input  1  reset, asynchronous, active-low.
I_REQ  input  [1:0]  access request per requester, level, held until ack.
I_WE  input  [1:0]  1 = write, 0 = read, per requester; valid while REQ high.
I_ADDRESS_0 / I_ADDRESS_1  input  P_ADDRESS_WIDTH  requester address.
I_DATA_0 / I_DATA_1  input  P_DATA_WIDTH  requester write data.
O_ACK  output  [1:0]  one-cycle completion pulse per requester.
O_DATA_0 / O_DATA_1  output  P_DATA_WIDTH  read data per requester.
O_BRAM_ADDRESS  output  P_ADDRESS_WIDTH  to BRAM port address.
O_BRAM_DATA  output  P_DATA_WIDTH  to BRAM port write data.
O_BRAM_WRITE_ENABLE  output  1  to BRAM port write enable.
I_BRAM_DATA  input  P_DATA_WIDTH  from BRAM port read data.

Behaviour:
- Reset (async, I_NRESET low):
  - State IDLE, priority pointer = 0.
  - O_ACK = 0, O_DATA_0 = O_DATA_1 = 0.
  - O_BRAM_ADDRESS = 0, O_BRAM_DATA = 0, O_BRAM_WRITE_ENABLE = 0.
- States: IDLE -> ACCESS -> WAIT -> DONE -> IDLE. Any state other than IDLE runs unconditionally; requests are ignored outside IDLE.
- IDLE, at each edge:
  - No REQ bit set: stay in IDLE.
  - Exactly one REQ set: grant that requester.
  - Both REQ set: grant the requester equal to the pointer, then set pointer = the other requester.
  - A single-requester grant also sets pointer = the other requester.
  - On grant: register grant id, O_BRAM_ADDRESS, O_BRAM_DATA, O_BRAM_WRITE_ENABLE = I_WE[id]; go to ACCESS.
- ACCESS:
  - BRAM signals stable; the BRAM samples them at the closing edge.
  - At that edge O_BRAM_WRITE_ENABLE returns to 0; address and data are held.
  - Go to WAIT.
- WAIT: I_BRAM_DATA valid for reads. At the closing edge:
  - Read: O_DATA_<id> <= I_BRAM_DATA.
  - Write: O_DATA_<id> unchanged.
  - O_ACK[id] <= 1; go to DONE.
- DONE: O_ACK[id] high for exactly this cycle; cleared at the closing edge; go to IDLE.
- Latency and throughput:
  - REQ sampled at edge e0, ACK high during e2..e3.
  - One access every 4 cycles.
  - O_BRAM_WRITE_ENABLE is high only during ACCESS (e0..e1).
- Handshake rule:
  - A requester deasserts REQ at the edge ending its ACK cycle.
  - REQ still high when IDLE samples (e4) is a new access.
  - REQ must not change address, data or WE while waiting for ACK; the arbiter registers these only at grant.
  - Dropping REQ before grant withdraws the request; dropping it after grant has no effect.
- O_DATA_n holds its last read value until that requester's next read completes. The other requester's output is never disturbed.
- Only one ACK bit is ever high, and never in consecutive cycles.
- Reset mid-operation: everything returns to reset values immediately and WE drops asynchronously. A write in ACCESS may or may not commit, and no ACK is issued; the requester re-issues.
- Address width is passed through unchanged; no wrap or bounds logic (max address 2^P_ADDRESS_WIDTH-1 is legal).

Test Plan:
- Single read: BRAM[5]=16'h1234, REQ[0]=1, WE[0]=0, ADDR_0=5 -> O_ACK[0] one cycle, 3 cycles after sampling edge; O_DATA_0=16'h1234; O_DATA_1 stays 0.
- Write then read: requester 1 writes 16'h00AA to 1023, then reads 1023 -> WE high exactly one cycle with address 1023; second ACK gives O_DATA_1=16'h00AA.
- Contention: both REQ held continuously, reads of addresses 0 and 1 -> grants alternate 0,1,0,1 starting with 0 after reset; each ACK 4 cycles apart.
- Late arrival: REQ[1] asserted during requester 0's WAIT -> ignored until IDLE; granted at next IDLE; O_ACK[1] 4 cycles after O_ACK[0].
- Reset mid-access: assert I_NRESET=0 during ACCESS of a write -> all outputs 0 immediately, no ACK; after release, pointer=0 and a fresh read of 0 completes normally.
- Withdrawal: REQ[0] pulsed for a cycle while state is DONE for requester 1 -> no grant, no ACK[0], state returns to IDLE and stays.
